wb_stage: RTL and testbench

Write-back stage of the five-stage MIPS pipeline. Accepts completed instructions from the memory stage over a valid/ready handshake, waits for load data where needed, and forms the final result: ALU value, sign-extended byte, full word, or link address. Drives the register-file write port of the decode stage (`reg_write`/`write_reg`/`write_data`), which the decode stage also uses as its same-cycle forwarding source.

---
 rtl/wb_stage.sv | 167 ++++++++++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: load wait, result select, register-file write port
// Optional retired-instruction counter port enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_write_reg,
  input  logic [31:0] in_alu_result,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_npc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        mem_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] retire_q, retire_d;

  logic [7:0]  cnt_inc;
  logic [7:0]  lb_byte;
  logic        in_writes;
  logic        in_is_load;
  logic [4:0]  in_dest;

  always_comb begin
    in_writes = 1'b0;
    case (in_op)
      OP_RTYPE, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001111, OP_LW, OP_LB, OP_JAL: in_writes = 1'b1;
      default: in_writes = 1'b0;
    endcase
  end

  assign in_is_load = (in_op == OP_LW) || (in_op == OP_LB);
  assign in_dest    = (in_op == OP_JAL) ? 5'd31 : in_write_reg;
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    lb_byte = mem_rdata[7:0];
    case (addr_lo_q)
      2'd0: lb_byte = mem_rdata[7:0];
      2'd1: lb_byte = mem_rdata[15:8];
      2'd2: lb_byte = mem_rdata[23:16];
      2'd3: lb_byte = mem_rdata[31:24];
      default: lb_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wreg_d       = wreg_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    mem_err_d    = mem_err_q;
    retire_d     = retire_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            op_d      = in_op;
            wreg_d    = in_write_reg;
            addr_lo_d = in_addr_lo;
            cnt_d     = 8'd0;
            state_d   = WAIT_MEM;
          end else begin
            retire_d = retire_q + 32'd1;
            if (in_writes) begin
              write_reg_d  = in_dest;
              write_data_d = (in_op == OP_JAL) ? (in_npc + 32'd4) : in_alu_result;
              reg_write_d  = (in_dest != 5'd0);
            end
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          state_d      = IDLE;
          retire_d     = retire_q + 32'd1;
          write_reg_d  = wreg_q;
          write_data_d = (op_q == OP_LW) ? mem_rdata : {{24{lb_byte[7]}}, lb_byte};
          reg_write_d  = (wreg_q != 5'd0);
        end else if (cnt_inc == TIMEOUT_C) begin
          // Abandoned load: flag it and retire nothing.
          state_d   = IDLE;
          mem_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= 6'd0;
      wreg_q       <= 5'd0;
      addr_lo_q    <= 2'd0;
      cnt_q        <= 8'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      mem_err_q    <= 1'b0;
      retire_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wreg_q       <= wreg_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      mem_err_q    <= mem_err_d;
      retire_q     <= retire_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign mem_err    = mem_err_q;

`ifdef WB_RETIRE_CNT_EN
  assign retire_cnt = retire_q;
`else
  logic unused_retire;
  assign unused_retire = ^retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage (MEM_TIMEOUT=4)
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_write_reg;
  logic [31:0] in_alu_result;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_npc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        mem_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retire = 0;

  wb_stage #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_write_reg (in_write_reg),
    .in_alu_result(in_alu_result),
    .in_addr_lo   (in_addr_lo),
    .in_npc       (in_npc),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .mem_err      (mem_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] wr, input logic [31:0] alu,
                       input logic [1:0] lo, input logic [31:0] npc);
    check("ready_before_issue", 32'(in_ready), 32'd1);
    in_op = op; in_write_reg = wr; in_alu_result = alu; in_addr_lo = lo; in_npc = npc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic we, input logic [4:0] wr,
                              input logic [31:0] data);
    check({tag, "_we"},   32'(reg_write), 32'(we));
    check({tag, "_reg"},  32'(write_reg), 32'(wr));
    check({tag, "_data"}, write_data, data);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = 6'd0; in_write_reg = 5'd0;
    in_alu_result = 32'd0; in_addr_lo = 2'd0; in_npc = 32'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    expect_write("reset", 1'b0, 5'd0, 32'd0);
    check("reset_err", 32'(mem_err), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
`ifdef WB_RETIRE_CNT_EN
    check("reset_retire", retire_cnt, 32'd0);
`endif
    #2 rst = 1'b1;
    tick();

    // ADDI r5 = 0x1234, single-cycle pulse with held data
    issue(6'b001000, 5'd5, 32'h0000_1234, 2'd0, 32'd0); exp_retire++;
    expect_write("addi", 1'b1, 5'd5, 32'h0000_1234);
    tick();
    expect_write("addi_hold", 1'b0, 5'd5, 32'h0000_1234);

    // LB offset 2, data back on the third wait edge; rvalid at accept is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    issue(6'b100000, 5'd7, 32'd0, 2'd2, 32'd0);
    mem_rvalid = 1'b0;
    check("lb_ready_accept", 32'(in_ready), 32'd0);
    check("lb_no_early_we", 32'(reg_write), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lb_ready_wait", 32'(in_ready), 32'd0);
      check("lb_wait_we", 32'(reg_write), 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h12F4_5678;
    tick(); exp_retire++;
    mem_rvalid = 1'b0;
    expect_write("lb", 1'b1, 5'd7, 32'hFFFF_FFF4);
    check("lb_ready_back", 32'(in_ready), 32'd1);

    // LB offset 3 positive byte
    issue(6'b100000, 5'd8, 32'd0, 2'd3, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h7F00_0080;
    tick(); exp_retire++;
    mem_rvalid = 1'b0;
    expect_write("lb3", 1'b1, 5'd8, 32'h0000_007F);

    // LW ignores addr_lo
    issue(6'b100011, 5'd10, 32'd0, 2'd1, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); exp_retire++;
    mem_rvalid = 1'b0;
    expect_write("lw", 1'b1, 5'd10, 32'hDEAD_BEEF);

    // JAL forces r31 and npc+4
    issue(6'b000011, 5'd0, 32'h5555_5555, 2'd0, 32'h0040_0010); exp_retire++;
    expect_write("jal", 1'b1, 5'd31, 32'h0040_0014);

    // JAL with npc wrapping past 2^32
    issue(6'b000011, 5'd4, 32'd0, 2'd0, 32'hFFFF_FFFE); exp_retire++;
    expect_write("jal_wrap", 1'b1, 5'd31, 32'h0000_0002);

    // Back-to-back ORI then ADD
    in_op = 6'b001101; in_write_reg = 5'd3; in_alu_result = 32'h0000_AAAA; in_valid = 1'b1;
    tick(); exp_retire++;
    expect_write("ori_b2b", 1'b1, 5'd3, 32'h0000_AAAA);
    in_op = 6'b000000; in_write_reg = 5'd4; in_alu_result = 32'h0000_5555;
    tick(); exp_retire++;
    in_valid = 1'b0;
    expect_write("add_b2b", 1'b1, 5'd4, 32'h0000_5555);

    // ADD to r0 suppressed but port updates; SW never writes
    issue(6'b000000, 5'd0, 32'h0000_0099, 2'd0, 32'd0); exp_retire++;
    expect_write("add_r0", 1'b0, 5'd0, 32'h0000_0099);
    issue(6'b101011, 5'd6, 32'h0000_0777, 2'd0, 32'd0); exp_retire++;
    check("sw_we", 32'(reg_write), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("retire_after_sw", retire_cnt, 32'(exp_retire));
`endif

    // LW timeout after 4 wait cycles
    issue(6'b100011, 5'd12, 32'd0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_err_wait", 32'(mem_err), 32'd0);
      check("to_ready_wait", 32'(in_ready), 32'd0);
    end
    tick();
    check("to_err", 32'(mem_err), 32'd1);
    check("to_ready", 32'(in_ready), 32'd1);
    check("to_we", 32'(reg_write), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("retire_timeout", retire_cnt, 32'(exp_retire));
`endif
    issue(6'b000000, 5'd9, 32'h0000_0042, 2'd0, 32'd0); exp_retire++;
    expect_write("add_after_to", 1'b1, 5'd9, 32'h0000_0042);
    check("err_sticky", 32'(mem_err), 32'd1);

    // Reset two cycles into WAIT_MEM
    issue(6'b100011, 5'd13, 32'd0, 2'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    expect_write("mid_rst", 1'b0, 5'd0, 32'd0);
    check("mid_rst_err", 32'(mem_err), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
`ifdef WB_RETIRE_CNT_EN
    check("mid_rst_retire", retire_cnt, 32'd0);
`endif
    #2 rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    expect_write("post_rst_rvalid", 1'b0, 5'd0, 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
